// File: rtl/half_sub_pkg.sv
// rtl/half_sub_pkg.sv - shared helpers and lane truth constants for half_sub
package half_sub_pkg;

  // Width needed to hold a borrow count from 0 up to width inclusive.
  function automatic int calc_cnt_w(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

  // Single-lane truth tables, bit index is {a, b}.
  localparam logic [3:0] LANE_E_TRUTH   = 4'b0110;
  localparam logic [3:0] LANE_BOR_TRUTH = 4'b0010;

endpackage

// File: rtl/half_sub_cell.sv
// rtl/half_sub_cell.sv - one-bit combinational half subtractor lane
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic e,
  output logic bor
);

  // Difference is set when the bits differ; borrow only when subtracting 1 from 0.
  assign e   = a ^ b;
  assign bor = ~a & b;

endmodule

// File: rtl/half_sub.sv
// rtl/half_sub.sv - registered multi-lane half subtractor with borrow status
module half_sub
  import half_sub_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] bor,
  output logic             bor_any,
  output logic [CNT_W-1:0] bor_count,
  output logic             bor_sticky
);

  logic [WIDTH-1:0] e_next;
  logic [WIDTH-1:0] bor_next;
  logic [CNT_W-1:0] cnt_next;

  // Lanes are fully independent; no borrow chains between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .e   (e_next[i]),
      .bor (bor_next[i])
    );
  end

  // Popcount of the incoming borrows so the registered count matches the registered bor.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + CNT_W'(bor_next[i]);
    end
  end

  // Result registers: capture on in_valid, otherwise hold data and drop out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      e         <= '0;
      bor       <= '0;
      bor_any   <= 1'b0;
      bor_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        e         <= e_next;
        bor       <= bor_next;
        bor_any   <= |bor_next;
        bor_count <= cnt_next;
      end
    end
  end

  // Sticky borrow: a new borrow outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bor_sticky <= 1'b0;
    end else if (in_valid && (|bor_next)) begin
      bor_sticky <= 1'b1;
    end else if (clr_sticky) begin
      bor_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_half_sub.sv
// tb/tb_half_sub.sv - scoreboard bench for half_sub at WIDTH=4 and WIDTH=1
module tb_half_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_sticky = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;

  logic       out_valid4, any4, sticky4;
  logic [3:0] e4, bor4;
  logic [2:0] cnt4;
  logic       out_valid1, any1, sticky1;
  logic [0:0] e1, bor1, cnt1;

  half_sub #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid4),
    .e          (e4),
    .bor        (bor4),
    .bor_any    (any4),
    .bor_count  (cnt4),
    .bor_sticky (sticky4)
  );

  half_sub #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a[0:0]),
    .b          (b[0:0]),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid1),
    .e          (e1),
    .bor        (bor1),
    .bor_any    (any1),
    .bor_count  (cnt1),
    .bor_sticky (sticky1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] e;
    logic [3:0] bor;
    logic       any;
    logic [2:0] cnt;
    logic       e1;
    logic       bor1;
    logic       any1;
    logic       cnt1;
  } exp_t;

  exp_t q[$];
  exp_t held = '0;
  logic sticky4_m = 1'b0;
  logic sticky1_m = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each lane is a signed subtraction of two single bits: nonzero gives e, negative gives a borrow.
  function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv);
    exp_t r;
    int   n;
    int   d;
    r = '0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(av[i]) - int'(bv[i]);
      r.e[i]   = (d != 0);
      r.bor[i] = (d < 0);
      if (d < 0) n++;
    end
    r.any  = (n > 0);
    r.cnt  = 3'(n);
    r.e1   = (av[0] != bv[0]);
    r.bor1 = (int'(av[0]) - int'(bv[0]) < 0);
    r.any1 = r.bor1;
    r.cnt1 = r.bor1;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic clr);
    exp_t r;
    @(negedge clk);
    in_valid   = v;
    a          = av;
    b          = bv;
    clr_sticky = clr;
    r = model(av, bv);
    if (v) q.push_back(r);
    if (v && r.bor != 0) sticky4_m = 1'b1;
    else if (clr)        sticky4_m = 1'b0;
    if (v && r.bor1)     sticky1_m = 1'b1;
    else if (clr)        sticky1_m = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid4"}, out_valid4, 0);
    chk({tag, "_e4"},         e4, 0);
    chk({tag, "_bor4"},       bor4, 0);
    chk({tag, "_any4"},       any4, 0);
    chk({tag, "_cnt4"},       cnt4, 0);
    chk({tag, "_sticky4"},    sticky4, 0);
    chk({tag, "_out_valid1"}, out_valid1, 0);
    chk({tag, "_e1"},         e1, 0);
    chk({tag, "_bor1"},       bor1, 0);
    chk({tag, "_sticky1"},    sticky1, 0);
  endtask

  // Asserts rst right now (off any edge), checks the immediate clear and the hold period.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    chk_zero({tag, "_async"});
    q.delete();
    held      = '0;
    sticky4_m = 1'b0;
    sticky1_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 4'($urandom);
      b = 4'($urandom);
      chk_zero({tag, "_hold"});
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  // Monitor: pops one expectation whenever a result is due and checks data and hold behaviour.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("out_valid4", out_valid4, q.size() > 0);
      chk("out_valid1", out_valid1, q.size() > 0);
      if (q.size() > 0) held = q.pop_front();
      chk("e4",      e4,      held.e);
      chk("bor4",    bor4,    held.bor);
      chk("any4",    any4,    held.any);
      chk("cnt4",    cnt4,    held.cnt);
      chk("e1",      e1,      held.e1);
      chk("bor1",    bor1,    held.bor1);
      chk("any1",    any1,    held.any1);
      chk("cnt1",    cnt1,    held.cnt1);
      chk("sticky4", sticky4, sticky4_m);
      chk("sticky1", sticky1, sticky1_m);
    end
  end

  initial begin
    #2;
    in_valid = 1'b1;
    a = 4'($urandom);
    b = 4'($urandom);
    reset_pulse("rst0");

    // Lane truth table on bit 0 (the WIDTH=1 instance sees exactly these pairs).
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    drive(1'b1, 4'b0001, 4'b0001, 1'b0);

    // Multi-lane vectors.
    drive(1'b1, 4'b0101, 4'b0011, 1'b0);
    drive(1'b1, 4'b0000, 4'b1111, 1'b0);

    // Hold while inputs toggle with in_valid low.
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'($urandom), 4'($urandom), 1'b0);

    // Sticky clear alone, then clear colliding with a new borrow.
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 4'b0001, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Reset between two valid transactions.
    drive(1'b1, 4'b0010, 4'b1101, 1'b0);
    @(posedge clk);
    #3;
    reset_pulse("rst_mid");
    drive(1'b1, 4'b0001, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/half_sub.md
Name: half_sub

Overview:
- Registered, WIDTH-lane bitwise half subtractor.
- Each lane computes difference `e = a XOR b` and borrow `bor = (NOT a) AND b`.
- Results are captured one clock after an accepted input. Aggregate borrow status is also provided: any-borrow flag, borrow popcount, and a sticky flag.
- Used as a leaf arithmetic primitive and as the borrow-generation stage feeding wider subtractors.

Parameters:
- WIDTH, 1, number of independent half-subtractor lanes (≥1).
- CNT_W, $clog2(WIDTH+1), width of the borrow count output. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  qualifies a/b for capture this cycle
- a  in  WIDTH  minuend bits
- b  in  WIDTH  subtrahend bits
- clr_sticky  in  1  synchronous clear of bor_sticky
- out_valid  out  1  e/bor/bor_any/bor_count hold a fresh result this cycle
- e  out  WIDTH  per-lane difference, a XOR b
- bor  out  WIDTH  per-lane borrow, ~a & b
- bor_any  out  1  OR-reduction of bor
- bor_count  out  CNT_W  number of set bits in bor
- bor_sticky  out  1  set once any accepted operand produced a borrow

Behaviour:
- Reset (rst=1, asynchronous, any time) forces out_valid, e, bor, bor_any, bor_count and bor_sticky to 0 immediately. They stay 0 while rst is high.
- Lane function, per bit i:
  - a=0,b=0 → e=0, bor=0
  - a=1,b=0 → e=1, bor=0
  - a=0,b=1 → e=1, bor=1
  - a=1,b=1 → e=0, bor=0
- Lanes are independent: no borrow propagates between lanes.
- Latency is 1 cycle. If in_valid=1 at rising edge N, then after edge N:
  - e and bor hold the results for the sampled a/b.
  - bor_any and bor_count are computed from those same registered results.
  - out_valid=1 for exactly that cycle.
- If in_valid=0 at an edge: out_valid goes to 0, and e/bor/bor_any/bor_count hold their previous values.
- Back-to-back in_valid gives one result per cycle. There is no backpressure and no stall.
- bor_count range is 0..WIDTH and is never truncated.
- bor_sticky:
  - Set at an edge where in_valid=1 and the new bor is nonzero.
  - Cleared at an edge where clr_sticky=1.
  - If both happen at the same edge, set wins and bor_sticky=1.
  - Otherwise it holds.
- clr_sticky has no effect on any other output.
- Reset asserted mid-stream discards the captured result. The first in_valid after rst deasserts behaves like the first transaction after power-up.
- X-free: all outputs are registered and fully reset.

Decomposition:
- Shared package half_sub_pkg:
  - function computing CNT_W from WIDTH.
  - localparam lane truth constants for bench reuse.
- Sub-module half_sub_cell: purely combinational, 1-bit a, b → e, bor. Instantiated WIDTH times via generate.
- The top level holds the registers, the reductions (OR, popcount) and the sticky logic.

Test Plan:
- Reset: assert rst with in_valid=1 and random a/b, without a clock edge → all outputs 0 immediately; all stay 0 for 3 cycles while rst is high.
- WIDTH=1 truth table: drive (a,b) = (0,0), (1,0), (0,1), (1,1) on consecutive cycles with in_valid=1 → one cycle later, (e,bor) = (0,0), (1,0), (1,1), (0,0); out_valid=1 on each of the 4 cycles; bor_sticky=1 from the third result onward.
- WIDTH=4 with a=4'b0101, b=4'b0011 → e=4'b0110, bor=4'b0010, bor_any=1, bor_count=1. Then a=4'b0000, b=4'b1111 → e=4'b1111, bor=4'b1111, bor_count=4.
- Hold: in_valid=1 with a=0,b=1, then in_valid=0 while a/b toggle for 3 cycles → out_valid=0 on those cycles; e=1 and bor=1 are retained.
- Sticky: with bor_sticky=1, pulse clr_sticky alone → 0 next cycle. Then clr_sticky=1 together with in_valid=1, a=0, b=1 → bor_sticky=1.
- Reset mid-stream: assert rst between two valid transactions → outputs go to 0 asynchronously. After release, the next input a=1,b=0 yields e=1, bor=0, bor_sticky=0.
